// File: rtl/mem_access_unit_if.sv
// Data-side memory bus between the M-stage access unit and the memory system.
// master: the access unit (issues requests), slave: memory / cache side.
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: turns the M-stage instruction into one request on
// the addr_ok/data_ok bus, stalls the pipeline while the access is in flight,
// and aligns/extends load data.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned half/word
// accesses (adelM/adesM) and suppress their bus requests.
module mem_access_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_readM,
  input  logic              mem_writeM,
  input  logic [1:0]        mem_sizeM,
  input  logic              load_unsignedM,
  input  logic [31:0]       aluoutM,
  input  logic [31:0]       rt_valueM,
  input  logic              cancelM,
  input  logic              m_advance,
  mem_access_unit_if.master bus,
  output logic [31:0]       mem_rdataM,
  output logic              mem_stall,
  output logic              adelM,
  output logic              adesM
);

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_t;

  // Everything a request carries, plus what the load path needs later.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        uns;
  } access_t;

  function automatic logic [3:0] strb_of(input logic wr, input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    if (wr) begin
      case (size)
        2'b00:   s = 4'b0001 << off;
        2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] rt);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{rt[7:0]}};
      2'b01:   d = {2{rt[15:0]}};
      default: d = rt;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_of(input logic [31:0] raw, input logic [1:0] size,
                                          input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  state_t      state, state_nx;
  access_t     live, held, drive;
  logic        addr_err;
  logic        access;
  logic        discard_q;
  logic        discard_hit;
  logic [31:0] rdata_q;
  logic [31:0] load_src;

`ifdef MEM_ALIGN_CHECK_EN
  logic is_half, is_word;
  assign is_half  = (mem_sizeM == 2'b01);
  assign is_word  = mem_sizeM[1];
  assign addr_err = (is_half & aluoutM[0]) | (is_word & (aluoutM[1:0] != 2'b00));
  assign adelM    = mem_readM & addr_err;
  assign adesM    = mem_writeM & addr_err;
`else
  assign addr_err = 1'b0;
  assign adelM    = 1'b0;
  assign adesM    = 1'b0;
`endif

  assign access      = (mem_readM | mem_writeM) & ~cancelM & ~addr_err;
  // A flush that lands while data is outstanding, now or earlier, kills the result.
  assign discard_hit = discard_q | cancelM;

  // Package the live M-stage instruction as a bus access.
  always_comb begin
    live.wr    = mem_writeM;
    live.size  = mem_sizeM;
    live.addr  = aluoutM;
    live.wdata = wdata_of(mem_sizeM, rt_valueM);
    live.wstrb = strb_of(mem_writeM, mem_sizeM, aluoutM[1:0]);
    live.uns   = load_unsignedM;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no branch leaves state_nx unassigned and infers a latch.
    state_nx = state;
    case (state)
      IDLE:      if (access) state_nx = bus.data_addr_ok ? WAIT_DATA : WAIT_ADDR;
      WAIT_ADDR: begin
        if (cancelM)               state_nx = IDLE;
        else if (bus.data_addr_ok) state_nx = WAIT_DATA;
      end
      WAIT_DATA: if (bus.data_data_ok) state_nx = (discard_hit | m_advance) ? IDLE : DONE;
      DONE:      if (m_advance) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Bus request, stall and load-result outputs.
  always_comb begin
    drive         = (state == IDLE) ? live : held;
    bus.data_req  = 1'b0;
    mem_stall     = 1'b0;
    case (state)
      IDLE: begin
        bus.data_req = access;
        mem_stall    = access;
      end
      WAIT_ADDR: begin
        bus.data_req = ~cancelM;
        mem_stall    = 1'b1;
      end
      WAIT_DATA: mem_stall = ~bus.data_data_ok;
      default:   ;
    endcase
    bus.data_wr    = drive.wr;
    bus.data_size  = drive.size;
    bus.data_addr  = drive.addr;
    bus.data_wdata = drive.wdata;
    bus.data_wstrb = drive.wstrb;
    load_src       = (state == WAIT_DATA && bus.data_data_ok) ? bus.data_rdata : rdata_q;
    mem_rdataM     = load_of(load_src, held.size, held.addr[1:0], held.uns);
  end

  // Latch the issued access, track discards, capture returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the capture register is reset as well, so a load result never leaks across reset.
      held      <= '0;
      discard_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      if (state == IDLE && access) held <= live;
      if (state == WAIT_DATA) discard_q <= bus.data_data_ok ? 1'b0 : discard_hit;
      else                    discard_q <= 1'b0;
      if (state == WAIT_DATA && bus.data_data_ok && !discard_hit) rdata_q <= bus.data_rdata;
    end
  end

endmodule
